gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Parametrised general-purpose I/O controller for the rysyCore peripheral bus: up to 32 bidirectional pins with per-pin direction, atomic set/clear/toggle of outputs, a two-stage input synchroniser, and per-pin edge-triggered interrupts latched into a write-1-to-clear pending register. It sits on the same byte-enabled, single-cycle peripheral bus as the existing simple LED GPIO and replaces it wherever inputs or interrupts are needed.

## Interface
- `N`, default 8: number of pins, 1..32; register bits `[31:N]` read 0 and ignore writes.
- `OUT_INVERT`, default 1: when 1, pin outputs are the bitwise inverse of OUT, for active-low board LEDs.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `addr`, input, 8: byte address of the register; `addr[1:0]` is ignored.
- `be`, input, 4: byte enables for writes; `be[k]` covers `wdata[8k+7:8k]`.
- `wdata`, input, 32: write data.
- `we`, input, 1: write strobe, one cycle per access.
- `q`, output, 32: read data, combinational from `addr` and the current register state.
- `gpio_i`, input, N: asynchronous pin inputs.
- `gpio_o`, output, N: pin output values.
- `gpio_oe`, output, N: pin output enables, 1 = drive.
- `irq`, output, 1: registered level interrupt.

## Operation
- Register map by `addr[7:2]`:
  - 0x00 OUT, RW.
  - 0x04 DIR, RW, 1 = output.
  - 0x08 IN, RO, returns the synchronised pins.
  - 0x0C SET, WO: OUT |= wdata.
  - 0x10 CLR, WO: OUT &= ~wdata.
  - 0x14 TGL, WO: OUT ^= wdata.
  - 0x18 RISE, RW: rising-edge detect enable per pin.
  - 0x1C FALL, RW: falling-edge detect enable per pin.
  - 0x20 IE, RW: interrupt enable.
  - 0x24 IP, RW1C: interrupt pending.
- Unmapped addresses read 0 and ignore writes. Reads of SET, CLR and TGL return 0. Writes to IN are ignored.
- Byte-enable mask `m = {{8{be[3]}},{8{be[2]}},{8{be[1]}},{8{be[0]}}}`. Every write affects only bits where `m = 1`.
  - Plain RW: `R <= (R & ~m) | (wdata & m)`.
  - SET, CLR and TGL apply `wdata & m`.
  - IP clears the bits where `wdata & m` is 1.
- Outputs:
  - `gpio_o = OUT[N-1:0] ^ {N{OUT_INVERT}}`.
  - `gpio_oe = DIR[N-1:0]`.
  - OUT is held independently of DIR. A pin switched to output drives the current OUT value.
- Synchroniser, per pin, three flops:
  - `s1 <= gpio_i`, `s2 <= s1`, `s3 <= s2`.
  - IN = `s2`.
  - `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- Edge detection and interrupt:
  - Event per pin: `ev = (rise & RISE) | (fall & FALL)`. RISE and FALL both set means any edge.
  - Edges are detected regardless of DIR, so an output pin read back through its pad can interrupt.
  - `IP <= (IP & ~clr) | ev`. Set wins over a simultaneous W1C on the same bit.
  - IP latches events regardless of IE.
  - `irq <= |(IP & IE)`, registered.
- Reset values:
  - OUT, DIR, RISE, FALL, IE, IP, s1, s2, s3 and `irq` are all 0.
  - `gpio_oe` = 0.
  - `gpio_o` = all-ones if `OUT_INVERT`, else 0.
  - Because RISE and FALL reset to 0, no pending bit can set until software enables detection. A pin already high at reset yields a rising edge only if RISE is enabled before s2 rises.

## Timing
- Writes take effect at the clk edge where `we = 1`. `gpio_o`/`gpio_oe` change in the same cycle the register updates (E0).
- Reads have zero latency: `q` reflects register state in the same cycle as `addr`. A read in the cycle after a write returns the new value.
- Pin transition sampled at edge E0 (into s1):
  - IN shows it after E1.
  - IP bit set at E2.
  - `irq` asserts at E3.
- Latency from IP or IE change to `irq` change is 1 cycle. `irq` deasserts the cycle after the last enabled pending bit is cleared or its IE bit is dropped.
- Pulses shorter than one clk period may be missed. Each distinct s2 transition produces exactly one event.
- Reset asserted mid-operation clears all state at that edge. During reset, writes are ignored and `irq` = 0.

## Test plan
- Reset with `N=8`, `OUT_INVERT=1` -> `gpio_o=0xFF`, `gpio_oe=0x00`, `irq=0`, and all registers read 0.
- Write OUT=0xA5 with `be=4'b0001`, then SET 0x0F, CLR 0x81, TGL 0xFF -> OUT reads 0xA5, 0xAF, 0x2E, 0xD1 in turn; `gpio_o` equals the inverse each time. A write of 0xFFFF00FF with `be=4'b0010` leaves OUT unchanged.
- RISE=0x01, IE=0x01, then `gpio_i[0]` goes 0->1 -> IN[0]=1 after 2 edges, IP=0x01 after 3, `irq`=1 after 4. Writing IP=0x01 drops `irq` one cycle later.
- RISE=FALL=0x02, then toggle `gpio_i[1]` twice with 4-cycle spacing; clear IP between the toggles -> IP[1] sets on each edge. With IE=0, IP still sets and `irq` stays 0.
- Rising edge on pin 0 coincides with an IP W1C of bit 0 -> IP[0] remains 1.
- `N=4`: write 0xFFFFFFFF to OUT, DIR and IE -> each reads 0x0000000F. A read of 0x40 returns 0.

Source files
------------

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - general-purpose I/O controller with edge interrupts on the peripheral bus
module gpio_ctrl #(
   parameter int N          = 8,
   parameter int OUT_INVERT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   input  logic          we,
   output logic [31:0]   q,
   input  logic [N-1:0]  gpio_i,
   output logic [N-1:0]  gpio_o,
   output logic [N-1:0]  gpio_oe,
   output logic          irq
);

   localparam logic [5:0] A_OUT  = 6'h00;
   localparam logic [5:0] A_DIR  = 6'h01;
   localparam logic [5:0] A_IN   = 6'h02;
   localparam logic [5:0] A_SET  = 6'h03;
   localparam logic [5:0] A_CLR  = 6'h04;
   localparam logic [5:0] A_TGL  = 6'h05;
   localparam logic [5:0] A_RISE = 6'h06;
   localparam logic [5:0] A_FALL = 6'h07;
   localparam logic [5:0] A_IE   = 6'h08;
   localparam logic [5:0] A_IP   = 6'h09;

   logic [N-1:0] out_q, out_d;
   logic [N-1:0] dir_q, dir_d;
   logic [N-1:0] rise_q, rise_d;
   logic [N-1:0] fall_q, fall_d;
   logic [N-1:0] ie_q, ie_d;
   logic [N-1:0] ip_q, ip_d;
   logic [N-1:0] s1_q, s2_q, s3_q;
   logic         irq_q;

   logic [31:0]  m;
   logic [31:0]  wm;
   logic [N-1:0] mn, wn, ip_clr, ev;
   logic [N-1:0] rdata;
   logic         unused_bits;

   assign m  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign wm = wdata & m;
   assign mn = m[N-1:0];
   assign wn = wm[N-1:0];

   // Upper data bits (for N < 32) and the word-offset address bits have no effect
   assign unused_bits = ^{addr[1:0], wm};

   // Each distinct synchronised transition yields one event on enabled edges
   assign ev = ((s2_q & ~s3_q) & rise_q) | ((~s2_q & s3_q) & fall_q);

   assign gpio_o  = out_q ^ {N{OUT_INVERT != 0}};
   assign gpio_oe = dir_q;
   assign irq     = irq_q;

   // Register write decode with byte-enable masking; edge events win over W1C
   always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      rise_d = rise_q;
      fall_d = fall_q;
      ie_d   = ie_q;
      ip_clr = '0;
      if (we) begin
         case (addr[7:2])
            A_OUT:   out_d  = (out_q & ~mn) | wn;
            A_DIR:   dir_d  = (dir_q & ~mn) | wn;
            A_SET:   out_d  = out_q | wn;
            A_CLR:   out_d  = out_q & ~wn;
            A_TGL:   out_d  = out_q ^ wn;
            A_RISE:  rise_d = (rise_q & ~mn) | wn;
            A_FALL:  fall_d = (fall_q & ~mn) | wn;
            A_IE:    ie_d   = (ie_q & ~mn) | wn;
            A_IP:    ip_clr = wn;
            default: ;
         endcase
      end
      ip_d = (ip_q & ~ip_clr) | ev;
   end

   // Combinational read mux; write-only and unmapped locations read 0
   always_comb begin
      rdata = '0;
      case (addr[7:2])
         A_OUT:   rdata = out_q;
         A_DIR:   rdata = dir_q;
         A_IN:    rdata = s2_q;
         A_RISE:  rdata = rise_q;
         A_FALL:  rdata = fall_q;
         A_IE:    rdata = ie_q;
         A_IP:    rdata = ip_q;
         default: rdata = '0;
      endcase
      q = '0;
      q[N-1:0] = rdata;
   end

   // State registers, synchroniser chain and registered interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         dir_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         ie_q   <= '0;
         ip_q   <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         irq_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         dir_q  <= dir_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         ie_q   <= ie_d;
         ip_q   <= ip_d;
         s1_q   <= gpio_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         irq_q  <= |(ip_q & ie_q);
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic [31:0] q8, q4;
   logic [7:0]  gpio_i8 = '0;
   logic [7:0]  gpio_o8, gpio_oe8;
   logic        irq8;
   logic [3:0]  gpio_i4 = '0;
   logic [3:0]  gpio_o4, gpio_oe4;
   logic        irq4;

   int total = 0;
   int bad   = 0;
   logic [31:0] rv;

   always #5 clk = ~clk;

   gpio_ctrl #(.N(8), .OUT_INVERT(1)) u8 (
      .clk(clk), .rst(rst), .addr(addr), .be(be), .wdata(wdata), .we(we), .q(q8),
      .gpio_i(gpio_i8), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .irq(irq8)
   );

   gpio_ctrl #(.N(4), .OUT_INVERT(1)) u4 (
      .clk(clk), .rst(rst), .addr(addr), .be(be), .wdata(wdata), .we(we), .q(q4),
      .gpio_i(gpio_i4), .gpio_o(gpio_o4), .gpio_oe(gpio_oe4), .irq(irq4)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = q8;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      total++; if (gpio_o8 !== 8'hFF) begin bad++; $display("FAIL reset_gpio_o got=%h exp=ff", gpio_o8); end
      total++; if (gpio_oe8 !== 8'h00) begin bad++; $display("FAIL reset_gpio_oe got=%h exp=00", gpio_oe8); end
      total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq8); end
      for (int i = 0; i < 10; i++) begin
         rd(8'(i * 4), rv);
         total++; if (rv !== 32'h0) begin bad++; $display("FAIL reset_reg_%0h got=%h exp=0", i * 4, rv); end
      end
   endtask

   task automatic test_out_ops;
      wr(8'h00, 32'h000000A5, 4'b0001);
      rd(8'h00, rv);
      total++; if (rv !== 32'hA5) begin bad++; $display("FAIL out_write got=%h exp=a5", rv); end
      total++; if (gpio_o8 !== 8'h5A) begin bad++; $display("FAIL out_write_pin got=%h exp=5a", gpio_o8); end
      wr(8'h0C, 32'h0000000F, 4'b1111);
      rd(8'h00, rv);
      total++; if (rv !== 32'hAF) begin bad++; $display("FAIL out_set got=%h exp=af", rv); end
      total++; if (gpio_o8 !== 8'h50) begin bad++; $display("FAIL out_set_pin got=%h exp=50", gpio_o8); end
      wr(8'h10, 32'h00000081, 4'b1111);
      rd(8'h00, rv);
      total++; if (rv !== 32'h2E) begin bad++; $display("FAIL out_clr got=%h exp=2e", rv); end
      total++; if (gpio_o8 !== 8'hD1) begin bad++; $display("FAIL out_clr_pin got=%h exp=d1", gpio_o8); end
      wr(8'h14, 32'h000000FF, 4'b1111);
      rd(8'h00, rv);
      total++; if (rv !== 32'hD1) begin bad++; $display("FAIL out_tgl got=%h exp=d1", rv); end
      total++; if (gpio_o8 !== 8'h2E) begin bad++; $display("FAIL out_tgl_pin got=%h exp=2e", gpio_o8); end
      wr(8'h00, 32'hFFFF00FF, 4'b0010);
      rd(8'h00, rv);
      total++; if (rv !== 32'hD1) begin bad++; $display("FAIL out_be_masked got=%h exp=d1", rv); end
      rd(8'h0C, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL set_reads_zero got=%h exp=0", rv); end
      wr(8'h04, 32'h0000000F, 4'b0001);
      total++; if (gpio_oe8 !== 8'h0F) begin bad++; $display("FAIL dir_oe got=%h exp=0f", gpio_oe8); end
      total++; if (gpio_o8 !== 8'h2E) begin bad++; $display("FAIL dir_keeps_out got=%h exp=2e", gpio_o8); end
   endtask

   task automatic test_rise_irq;
      wr(8'h18, 32'h01, 4'b1111);
      wr(8'h20, 32'h01, 4'b1111);
      gpio_i8[0] = 1'b1;
      tick(1);
      rd(8'h08, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL in_after_e0 got=%h exp=0", rv); end
      tick(1);
      rd(8'h08, rv);
      total++; if (rv !== 32'h1) begin bad++; $display("FAIL in_after_e1 got=%h exp=1", rv); end
      rd(8'h24, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL ip_after_e1 got=%h exp=0", rv); end
      tick(1);
      rd(8'h24, rv);
      total++; if (rv !== 32'h1) begin bad++; $display("FAIL ip_after_e2 got=%h exp=1", rv); end
      total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL irq_after_e2 got=%b exp=0", irq8); end
      tick(1);
      total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL irq_after_e3 got=%b exp=1", irq8); end
      wr(8'h20, 32'h00, 4'b1111);
      total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL irq_ie_drop_same got=%b exp=1", irq8); end
      tick(1);
      total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL irq_ie_drop_next got=%b exp=0", irq8); end
      wr(8'h20, 32'h01, 4'b1111);
      tick(1);
      total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL irq_ie_restore got=%b exp=1", irq8); end
      wr(8'h24, 32'h01, 4'b1111);
      rd(8'h24, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL ip_w1c got=%h exp=0", rv); end
      total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL irq_w1c_same got=%b exp=1", irq8); end
      tick(1);
      total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL irq_w1c_next got=%b exp=0", irq8); end
   endtask

   task automatic test_any_edge;
      wr(8'h20, 32'h00, 4'b1111);
      wr(8'h18, 32'h03, 4'b1111);
      wr(8'h1C, 32'h02, 4'b1111);
      gpio_i8[1] = 1'b1;
      tick(4);
      rd(8'h24, rv);
      total++; if (rv !== 32'h02) begin bad++; $display("FAIL any_rise_ip got=%h exp=02", rv); end
      total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL any_rise_irq got=%b exp=0", irq8); end
      wr(8'h24, 32'h02, 4'b1111);
      rd(8'h24, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL any_clear got=%h exp=0", rv); end
      gpio_i8[1] = 1'b0;
      tick(4);
      rd(8'h24, rv);
      total++; if (rv !== 32'h02) begin bad++; $display("FAIL any_fall_ip got=%h exp=02", rv); end
      total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL any_fall_irq got=%b exp=0", irq8); end
      wr(8'h24, 32'h02, 4'b1111);
      gpio_i8[0] = 1'b0;
      tick(4);
      rd(8'h24, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL fall_disabled got=%h exp=0", rv); end
   endtask

   task automatic test_set_wins;
      gpio_i8[0] = 1'b1;
      tick(2);
      wr(8'h24, 32'h01, 4'b1111);
      rd(8'h24, rv);
      total++; if (rv !== 32'h01) begin bad++; $display("FAIL set_wins got=%h exp=01", rv); end
      wr(8'h24, 32'h01, 4'b1111);
      rd(8'h24, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL set_wins_clear got=%h exp=0", rv); end
   endtask

   task automatic test_reset_mid;
      wr(8'h24, 32'h0, 4'b1111);
      rst = 1'b1;
      wr(8'h00, 32'h55, 4'b1111);
      rst = 1'b0;
      rd(8'h00, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL mid_reset_out got=%h exp=0", rv); end
      total++; if (gpio_oe8 !== 8'h00) begin bad++; $display("FAIL mid_reset_oe got=%h exp=00", gpio_oe8); end
      total++; if (gpio_o8 !== 8'hFF) begin bad++; $display("FAIL mid_reset_o got=%h exp=ff", gpio_o8); end
      rd(8'h18, rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL mid_reset_rise got=%h exp=0", rv); end
   endtask

   task automatic test_narrow;
      wr(8'h00, 32'hFFFFFFFF, 4'b1111);
      wr(8'h04, 32'hFFFFFFFF, 4'b1111);
      wr(8'h20, 32'hFFFFFFFF, 4'b1111);
      addr = 8'h00; #1;
      total++; if (q4 !== 32'h0000000F) begin bad++; $display("FAIL n4_out got=%h exp=0000000f", q4); end
      addr = 8'h04; #1;
      total++; if (q4 !== 32'h0000000F) begin bad++; $display("FAIL n4_dir got=%h exp=0000000f", q4); end
      addr = 8'h20; #1;
      total++; if (q4 !== 32'h0000000F) begin bad++; $display("FAIL n4_ie got=%h exp=0000000f", q4); end
      total++; if (gpio_o4 !== 4'h0) begin bad++; $display("FAIL n4_pin got=%h exp=0", gpio_o4); end
      total++; if (gpio_oe4 !== 4'hF) begin bad++; $display("FAIL n4_oe got=%h exp=f", gpio_oe4); end
      wr(8'h40, 32'hFFFFFFFF, 4'b1111);
      addr = 8'h40; #1;
      total++; if (q4 !== 32'h0) begin bad++; $display("FAIL n4_unmapped got=%h exp=0", q4); end
      total++; if (q8 !== 32'h0) begin bad++; $display("FAIL n8_unmapped got=%h exp=0", q8); end
      total++; if (irq4 !== 1'b0) begin bad++; $display("FAIL n4_irq got=%b exp=0", irq4); end
   endtask

   initial begin
      #1;
      test_reset;
      test_out_ops;
      test_rise_irq;
      test_any_edge;
      test_set_wins;
      test_reset_mid;
      test_narrow;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
